// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mux_tree_pipe
//  Purpose  : Pipelined N-to-1 multiplexer (N = 4**LEVELS) built from one
//             registered 4:1 level per pipeline stage. Valid and select
//             travel with the data; a global stall freezes everything.
//  Option   : define MUX_TREE_PIPE_SCAN_EN to build the internal scan
//             counter that can replace the external select.
//  Revision : 1.0  initial release
// ============================================================================
module mux_tree_pipe #(
   parameter int WIDTH  = 1,
   parameter int LEVELS = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [(4**LEVELS)*WIDTH-1:0]  w,
   input  logic [2*LEVELS-1:0]           s,
   input  logic                          stall,
   input  logic                          scan_en,
   output logic [WIDTH-1:0]              f,
   output logic                          out_valid,
   output logic [2*LEVELS-1:0]           out_sel,
   output logic [2*LEVELS-1:0]           scan_idx
);

   localparam int c_num_ch = 4**LEVELS;
   localparam int c_sel_w  = 2*LEVELS;

   // Select presented to the first tree level on this cycle.
   logic [c_sel_w-1:0] w_sel;

`ifdef MUX_TREE_PIPE_SCAN_EN
   logic [c_sel_w-1:0] r_scan_idx;

   // Scan counter: advances once per accepted scan request; the counter is
   // exactly log2(N) bits wide so it wraps from N-1 to 0 on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_idx <= '0;
      end else if (!stall && scan_en && in_valid) begin
         r_scan_idx <= r_scan_idx + c_sel_w'(1);
      end
   end

   // The request entering now uses the counter value before its increment.
   assign w_sel    = scan_en ? r_scan_idx : s;
   assign scan_idx = r_scan_idx;
`else
   logic w_unused_scan_en;

   assign w_unused_scan_en = scan_en;
   assign w_sel            = s;
   assign scan_idx         = '0;
`endif

   // One registered 4:1 level per stage; level k consumes select bits
   // [2k+1:2k] and shrinks the channel count by four.
   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int c_in_ch  = c_num_ch >> (2*k);
      localparam int c_out_ch = c_in_ch / 4;

      logic [c_in_ch*WIDTH-1:0]  w_din;
      logic                      w_vin;
      logic [c_sel_w-1:0]        w_sin;
      logic [c_out_ch*WIDTH-1:0] w_mux;
      logic [c_out_ch*WIDTH-1:0] r_data;
      logic                      r_valid;
      logic [c_sel_w-1:0]        r_sel;

      if (k == 0) begin : g_entry
         assign w_din = w;
         assign w_vin = in_valid;
         assign w_sin = w_sel;
      end else begin : g_inner
         assign w_din = g_level[k-1].r_data;
         assign w_vin = g_level[k-1].r_valid;
         assign w_sin = g_level[k-1].r_sel;
      end

      // Pick element sel[2k+1:2k] out of every group of four channels.
      always_comb begin
         w_mux = '0;
         for (int g = 0; g < c_out_ch; g++) begin
            w_mux[g*WIDTH +: WIDTH] =
               w_din[(4*g + int'(w_sin[2*k +: 2]))*WIDTH +: WIDTH];
         end
      end

      // Stage register: data/select load only with a valid request, so a
      // bubble leaves the last valid result in place (this is what makes
      // f and out_sel hold across bubbles at the final level).
      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
         end else if (!stall) begin
            r_valid <= w_vin;
            if (w_vin) begin
               r_data <= w_mux;
               r_sel  <= w_sin;
            end
         end
      end
   end

   assign f         = g_level[LEVELS-1].r_data;
   assign out_valid = g_level[LEVELS-1].r_valid;
   assign out_sel   = g_level[LEVELS-1].r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_tree_pipe
//  Purpose  : Self-checking bench for mux_tree_pipe. Three instances
//             (4b x 16 ch / 8b x 4 ch / 1b x 64 ch) run against a request
//             delay-line model; directed literal checks pin the model.
//  Option   : honours MUX_TREE_PIPE_SCAN_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   logic rst, stall, in_valid, scan_en;

   logic [63:0] w0;  logic [3:0] s0;  logic [3:0] f0;  logic v0;  logic [3:0] os0, sc0;
   logic [31:0] w1;  logic [1:0] s1;  logic [7:0] f1;  logic v1;  logic [1:0] os1, sc1;
   logic [63:0] w2;  logic [5:0] s2;  logic       f2;  logic v2;  logic [5:0] os2, sc2;

   always #5 clk = ~clk;

   mux_tree_pipe #(.WIDTH(4), .LEVELS(2)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .w(w0), .s(s0), .stall(stall),
      .scan_en(scan_en), .f(f0), .out_valid(v0), .out_sel(os0), .scan_idx(sc0));

   mux_tree_pipe #(.WIDTH(8), .LEVELS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .w(w1), .s(s1), .stall(stall),
      .scan_en(scan_en), .f(f1), .out_valid(v1), .out_sel(os1), .scan_idx(sc1));

   mux_tree_pipe #(.WIDTH(1), .LEVELS(3)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .w(w2), .s(s2), .stall(stall),
      .scan_en(scan_en), .f(f2), .out_valid(v2), .out_sel(os2), .scan_idx(sc2));

   int passed = 0;
   int total  = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      else
         passed++;
   endtask

   // ---------------- behavioural model: a delay line of whole requests ----
   typedef struct {
      logic        v;
      logic [63:0] d;
      int          sel;
   } req_t;

   req_t        mp [3][3];
   logic [63:0] mf [3];
   logic        mv [3];
   int          msel [3];
   int          mscan [3];

   int          m_l, m_w, m_n, m_sv, m_es;
   logic [63:0] m_wv;
   req_t        m_nr;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin m_l = 2; m_w = 4; m_wv = w0;           m_sv = int'(s0); end
            1:       begin m_l = 1; m_w = 8; m_wv = {32'd0, w1};  m_sv = int'(s1); end
            default: begin m_l = 3; m_w = 1; m_wv = w2;           m_sv = int'(s2); end
         endcase
         m_n = 1 << (2*m_l);
         if (rst) begin
            for (int j = 0; j < 3; j++) mp[i][j].v = 1'b0;
            mf[i] = 64'd0; mv[i] = 1'b0; msel[i] = 0; mscan[i] = 0;
         end else if (!stall) begin
            m_es = m_sv;
`ifdef MUX_TREE_PIPE_SCAN_EN
            if (scan_en) m_es = mscan[i];
            if (scan_en && in_valid) mscan[i] = (mscan[i] + 1) % m_n;
`endif
            m_nr.v   = in_valid;
            m_nr.d   = (m_wv >> (m_es*m_w)) & ((64'd1 << m_w) - 64'd1);
            m_nr.sel = m_es;
            for (int j = m_l-1; j > 0; j--) mp[i][j] = mp[i][j-1];
            mp[i][0] = m_nr;
            mv[i]    = mp[i][m_l-1].v;
            if (mv[i]) begin
               mf[i]   = mp[i][m_l-1].d;
               msel[i] = mp[i][m_l-1].sel;
            end
         end
      end
   end

   // ---------------- every-cycle comparison against the model ------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m0_f",    64'(f0),  mf[0]);
         chk("m0_val",  64'(v0),  64'(mv[0]));
         chk("m0_sel",  64'(os0), 64'(msel[0]));
         chk("m0_scan", 64'(sc0), 64'(mscan[0]));
         chk("m1_f",    64'(f1),  mf[1]);
         chk("m1_val",  64'(v1),  64'(mv[1]));
         chk("m1_sel",  64'(os1), 64'(msel[1]));
         chk("m1_scan", 64'(sc1), 64'(mscan[1]));
         chk("m2_f",    64'(f2),  mf[2]);
         chk("m2_val",  64'(v2),  64'(mv[2]));
         chk("m2_sel",  64'(os2), 64'(msel[2]));
         chk("m2_scan", 64'(sc2), 64'(mscan[2]));
      end
   end

   // Apply one cycle of inputs, then wait for the following falling edge.
   task automatic step(input logic v, input int sv, input logic st);
      in_valid = v;
      s0       = 4'(sv);
      stall    = st;
      w1       = $urandom;
      s1       = 2'($urandom);
      w2       = {$urandom, $urandom};
      s2       = 6'($urandom);
      @(negedge clk);
   endtask

   int q[$];

   initial begin
      rst = 1'b1; stall = 1'b0; in_valid = 1'b0; scan_en = 1'b0;
      s0 = '0; s1 = '0; s2 = '0; w1 = '0; w2 = '0;
      for (int i = 0; i < 16; i++) w0[i*4 +: 4] = 4'(i + 1);

      // Reset state
      step(0, 0, 0);
      chk_en = 1'b1;
      step(0, 0, 0);
      rst = 1'b0;
      chk("rst_f",    64'(f0),  64'd0);
      chk("rst_val",  64'(v0),  64'd0);
      chk("rst_sel",  64'(os0), 64'd0);
      chk("rst_scan", 64'(sc0), 64'd0);

      // Basic select: channel 5 carries 6, visible after two edges
      step(1, 5, 0);
      chk("basic_early_val", 64'(v0), 64'd0);
      step(0, 0, 0);
      chk("basic_f",   64'(f0),  64'd6);
      chk("basic_val", 64'(v0),  64'd1);
      chk("basic_sel", 64'(os0), 64'd5);
      step(0, 0, 0);
      chk("basic_hold_val", 64'(v0), 64'd0);
      chk("basic_hold_f",   64'(f0), 64'd6);

      // Full sweep, back-to-back
      for (int k = 0; k < 16; k++) begin
         step(1, k, 0);
         if (k >= 1) begin
            chk("sweep_f",   64'(f0), 64'(k % 16));
            chk("sweep_val", 64'(v0), 64'd1);
         end
      end
      step(0, 0, 0);
      chk("sweep_last_f",   64'(f0), 64'd0);
      chk("sweep_last_val", 64'(v0), 64'd1);
      step(0, 0, 0);
      chk("sweep_end_val", 64'(v0), 64'd0);

      // Stall: s = 3,4 then 3 stalled cycles then s = 5
      q.delete();
      step(1, 3, 0); if (v0) q.push_back(int'(f0));
      step(1, 4, 0); if (v0) q.push_back(int'(f0));
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1);
         chk("stall_hold_f", 64'(f0), 64'd4);
      end
      step(1, 5, 0); if (v0) q.push_back(int'(f0));
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0); if (v0) q.push_back(int'(f0));
      end
      chk("stall_count", 64'(q.size()), 64'd3);
      if (q.size() == 3) begin
         chk("stall_out0", 64'(q[0]), 64'd4);
         chk("stall_out1", 64'(q[1]), 64'd5);
         chk("stall_out2", 64'(q[2]), 64'd6);
      end

      // Scan mode (s deliberately scrambled)
      scan_en = 1'b1;
      for (int k = 0; k < 18; k++) begin
         step(1, (k*3) % 16, 0);
`ifdef MUX_TREE_PIPE_SCAN_EN
         chk("scan_idx", 64'(sc0), 64'((k + 1) % 16));
         if (k >= 1) chk("scan_sel", 64'(os0), 64'((k - 1) % 16));
`else
         chk("scan_idx_tied", 64'(sc0), 64'd0);
         if (k >= 1) chk("scan_sel_s", 64'(os0), 64'(((k - 1)*3) % 16));
`endif
      end
      scan_en = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);

      // Reset mid-stream, coinciding with stall
      step(1, 7, 0);
      rst = 1'b1;
      step(1, 8, 1);
      rst = 1'b0;
      chk("mrst_val",  64'(v0),  64'd0);
      chk("mrst_f",    64'(f0),  64'd0);
      chk("mrst_sel",  64'(os0), 64'd0);
      chk("mrst_scan", 64'(sc0), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         chk("mrst_no_ghost", 64'(v0), 64'd0);
      end
      step(1, 2, 0);
      step(0, 0, 0);
      chk("mrst_first_f",   64'(f0),  64'd3);
      chk("mrst_first_val", 64'(v0),  64'd1);
      chk("mrst_first_sel", 64'(os0), 64'd2);

      // Random traffic on all three instances
      for (int i = 0; i < 300; i++) begin
         w0      = {$urandom, $urandom};
         scan_en = ($urandom % 6) == 0;
         rst     = (i == 150);
         step(($urandom % 4) != 0, int'($urandom % 16), ($urandom % 4) == 0);
      end
      rst = 1'b0;
      step(0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer built as a tree of registered 4:1 stages, with N = 4^LEVELS inputs of WIDTH bits each. Each tree level is one pipeline stage. A valid bit and the select value travel with the data, and a global stall holds the pipeline. An optional scan counter sweeps all inputs in order. The block is the datapath selector used wherever several sampled buses must be funnelled onto one at full clock rate.

## Interface
- `WIDTH`, default 1: bits per input channel and of the output.
- `LEVELS`, default 2: number of 4:1 tree levels. N = 4^LEVELS inputs (default 16). Legal range 1..4.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the `w`/`s` pair (or scan select) on this cycle is a real request.
- `w`  in  N*WIDTH  packed inputs. Channel i occupies `w[i*WIDTH +: WIDTH]`.
- `s`  in  2*LEVELS  channel select, unsigned index.
- `stall`  in  1  hold the entire pipeline and the scan counter.
- `scan_en`  in  1  use the internal scan counter instead of `s`.
- `f`  out  WIDTH  selected channel data.
- `out_valid`  out  1  `f`/`out_sel` correspond to a valid request this cycle.
- `out_sel`  out  2*LEVELS  channel index that produced `f`.
- `scan_idx`  out  2*LEVELS  current scan counter value.

## Operation
- Effective select is `scan_idx` when `scan_en`=1 (macro present), otherwise `s`.
- Level 0 splits `w` into N/4 groups of 4 channels. It picks element `sel[1:0]` of each group: 0→first, 1→second, 2→third, 3→fourth.
- Level k uses `sel[2k+1:2k]` on the 4-to-1 groups of the level k-1 results. The select always reads as a plain binary index: `f` = channel `sel`.
- Each level registers its mux outputs, a valid bit and the not-yet-consumed select bits. The full select is carried to the end for `out_sel`.
- On cycles with `stall`=0, every stage register loads from its predecessor.
- On cycles with `stall`=1, every stage register, `f`, `out_valid`, `out_sel` and the scan counter hold.
- `in_valid`=0 injects a bubble: the stage valid bit is 0 and that stage's data is don't-care.
- When the final stage is valid, `f` and `out_sel` update. When it is a bubble, `f` and `out_sel` hold their last valid values and `out_valid`=0.
- Scan counter:
  - Increments on every cycle with `scan_en`=1, `in_valid`=1 and `stall`=0.
  - Wraps from N-1 to 0.
  - Holds while `scan_en`=0.
- Reset:
  - `rst` has priority over `stall`.
  - All valid bits clear, so in-flight requests are discarded.
  - `f`=0, `out_valid`=0, `out_sel`=0, `scan_idx`=0.

## Timing
- Latency is exactly LEVELS unstalled clock edges from a sampled request to `out_valid`=1. The default is 2.
- Throughput is one request per cycle. Back-to-back requests produce back-to-back outputs.
- Stalled cycles add latency one-for-one. No request is lost or duplicated across a stall.
- `w` is sampled only at level 0, on the request's entry edge. Later changes to `w` do not affect an in-flight request.
- The select that is used is the one present on the entry edge.
- Simultaneous `rst` and `stall`: reset wins.
- Simultaneous `scan_en` rising with `in_valid`: this request uses the current `scan_idx`, then the counter increments.
- Deasserting `rst` mid-stream: the first output appears LEVELS cycles after the first post-reset valid request.

## Configuration
- `MUX_TREE_PIPE_SCAN_EN` defined: the scan counter, `scan_en` select override and `scan_idx` behaviour are compiled in as described.
- `MUX_TREE_PIPE_SCAN_EN` undefined:
  - No counter is built.
  - `scan_en` is ignored and `s` is always used.
  - `scan_idx` is tied to 0.

## Test plan
- Basic select: WIDTH=4, LEVELS=2, channel i = i+1 (mod 16), `s`=5, one-cycle `in_valid` → after 2 edges `f`=6, `out_sel`=5, `out_valid`=1 for exactly one cycle, then `f` holds 6 with `out_valid`=0.
- Full sweep: `s`=0..15 on consecutive valid cycles → outputs on cycles 2..17 give `f`=1,2,…,15,0. `out_valid` stays continuously high.
- Stall: stream `s`=3,4,5 and assert `stall` for 3 cycles after the second request → outputs `f`=4,5,6 appear in order, the last one 3 cycles later than unstalled, with no repeat.
- Scan mode (macro defined): `scan_en`=1, `in_valid`=1 for 18 cycles → `out_sel` runs 0..15,0,1 and `scan_idx` wraps 15→0. With the macro undefined, `out_sel` follows `s`.
- Reset mid-stream: assert `rst` with 2 requests in flight → next cycle `out_valid`=0, `f`=0, `scan_idx`=0, and the discarded requests never emerge.
- Width/depth sweep: LEVELS=1 with WIDTH=8 and LEVELS=3 with WIDTH=1, random `w`/`s` → `f` equals `w[s]` after LEVELS cycles (latency 1 and 3 respectively).
